// File: rtl/perceptron_training_sequencer.sv
// Training-sample buffer and sequencer for the two-input neuron: loads labelled
// samples, kicks the neuron, and streams samples epoch by epoch until done or timeout.
module perceptron_training_sequencer #(
  parameter int DATA_W     = 7,
  parameter int T_W        = 2,
  parameter int DEPTH      = 8,
  parameter int EPOCH_W    = 8,
  parameter int MAX_EPOCHS = 100
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       loadValid,
  input  logic [DATA_W-1:0]          loadX1,
  input  logic [DATA_W-1:0]          loadX2,
  input  logic [T_W-1:0]             loadT,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       neuronReady,
  input  logic                       neuronDone,
  output logic                       neuronStart,
  output logic [DATA_W-1:0]          X1Bus,
  output logic [DATA_W-1:0]          X2Bus,
  output logic [T_W-1:0]             tBus,
  output logic [31:0]                nBus,
  output logic                       sampleValid,
  output logic [$clog2(DEPTH):0]     sampleCount,
  output logic [EPOCH_W-1:0]         epochCount,
  output logic                       busy,
  output logic                       trainDone,
  output logic                       timeout,
  output logic                       overflow,
  output logic                       emptyErr
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [EPOCH_W-1:0] EMAX = EPOCH_W'(MAX_EPOCHS);

  typedef enum logic [2:0] {S_IDLE, S_KICK, S_FEED, S_GAP, S_DONE} state_t;
  state_t r_state, w_next;

  logic [DATA_W-1:0] r_mem_x1 [DEPTH];
  logic [DATA_W-1:0] r_mem_x2 [DEPTH];
  logic [T_W-1:0]    r_mem_t  [DEPTH];

  logic [CW-1:0]      r_count, r_nbus;
  logic [IW-1:0]      r_idx;
  logic [EPOCH_W-1:0] r_epoch;
  logic [DATA_W-1:0]  r_x1, r_x2;
  logic [T_W-1:0]     r_t;
  logic r_train_done, r_timeout, r_overflow, r_empty_err;

  logic w_idle, w_feed, w_gap, w_accept, w_last, w_full, w_load, w_go;

  // Host-side priority in IDLE/DONE: clear, then start, then load.
  assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_feed   = (r_state == S_FEED);
  assign w_gap    = (r_state == S_GAP);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_load   = w_idle && loadValid && !clear && !start;
  assign w_go     = w_idle && start && !clear && (r_count != '0);
  assign w_accept = w_feed && neuronReady && !abort && !neuronDone;
  assign w_last   = ({1'b0, r_idx} == (r_count - 1'b1));

  always_comb begin
    w_next      = r_state;
    neuronStart = 1'b0;
    sampleValid = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (w_go) w_next = S_KICK;
      S_KICK: begin
        neuronStart = 1'b1;
        busy        = 1'b1;
        w_next      = abort ? S_IDLE : S_FEED;
      end
      S_FEED: begin
        sampleValid = 1'b1;
        busy        = 1'b1;
        if (abort)            w_next = S_IDLE;
        else if (neuronDone)  w_next = S_DONE;
        else if (neuronReady) w_next = S_GAP;
      end
      S_GAP: begin
        busy = 1'b1;
        if (abort)                w_next = S_IDLE;
        else if (neuronDone)      w_next = S_DONE;
        else if (r_epoch == EMAX) w_next = S_DONE;
        else                      w_next = S_FEED;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Buffer contents survive reset; only the count is cleared.
  always_ff @(posedge clk) begin
    if (w_load && !w_full) begin
      r_mem_x1[r_count[IW-1:0]] <= loadX1;
      r_mem_x2[r_count[IW-1:0]] <= loadX2;
      r_mem_t[r_count[IW-1:0]]  <= loadT;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_nbus       <= '0;
      r_idx        <= '0;
      r_epoch      <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_t          <= '0;
      r_train_done <= 1'b0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
      r_empty_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle) begin
        r_nbus <= r_count;
        if (clear) begin
          r_count      <= '0;
          r_overflow   <= 1'b0;
          r_train_done <= 1'b0;
          r_timeout    <= 1'b0;
          r_empty_err  <= 1'b0;
        end else if (start) begin
          if (r_count == '0) begin
            r_empty_err <= 1'b1;
          end else begin
            r_train_done <= 1'b0;
            r_timeout    <= 1'b0;
            r_empty_err  <= 1'b0;
            r_epoch      <= '0;
            r_idx        <= '0;
          end
        end else if (loadValid) begin
          if (w_full) r_overflow <= 1'b1;
          else        r_count    <= r_count + 1'b1;
        end
      end
      if (w_accept) begin
        if (w_last) begin
          r_idx <= '0;
          if (r_epoch != EMAX) r_epoch <= r_epoch + 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if ((w_feed || w_gap) && !abort && neuronDone) r_train_done <= 1'b1;
      if (w_gap && !abort && !neuronDone && (r_epoch == EMAX)) r_timeout <= 1'b1;
      // Present the next sample on entry to FEED; buses then hold through GAP/DONE.
      if ((w_next == S_FEED) && !w_feed) begin
        r_x1 <= r_mem_x1[r_idx];
        r_x2 <= r_mem_x2[r_idx];
        r_t  <= r_mem_t[r_idx];
      end
    end
  end

  assign X1Bus       = r_x1;
  assign X2Bus       = r_x2;
  assign tBus        = r_t;
  assign nBus        = 32'(r_nbus);
  assign sampleCount = r_count;
  assign epochCount  = r_epoch;
  assign trainDone   = r_train_done;
  assign timeout     = r_timeout;
  assign overflow    = r_overflow;
  assign emptyErr    = r_empty_err;

endmodule

// File: tb/tb_perceptron_training_sequencer.sv
// Directed bench: samples expected at the neuron are queued as stimulus is driven
// and checked by a handshake monitor; flags and counters are checked inline.
module tb_perceptron_training_sequencer;
  localparam int DATA_W = 7;
  localparam int T_W    = 2;
  localparam int DEPTH  = 8;
  localparam int EPOCH_W = 8;
  localparam int MAXE   = 2;
  localparam int SW     = 2*DATA_W + T_W;

  logic clk = 1'b0;
  logic rstN, loadValid, clear, start, abort, neuronReady, neuronDone;
  logic [DATA_W-1:0] loadX1, loadX2;
  logic [T_W-1:0] loadT;
  logic neuronStart, sampleValid, busy, trainDone, timeout, overflow, emptyErr;
  logic [DATA_W-1:0] X1Bus, X2Bus;
  logic [T_W-1:0] tBus;
  logic [31:0] nBus;
  logic [$clog2(DEPTH):0] sampleCount;
  logic [EPOCH_W-1:0] epochCount;

  perceptron_training_sequencer #(.DATA_W(DATA_W), .T_W(T_W), .DEPTH(DEPTH),
    .EPOCH_W(EPOCH_W), .MAX_EPOCHS(MAXE)) dut (
    .clk(clk), .rstN(rstN), .loadValid(loadValid), .loadX1(loadX1), .loadX2(loadX2),
    .loadT(loadT), .clear(clear), .start(start), .abort(abort),
    .neuronReady(neuronReady), .neuronDone(neuronDone), .neuronStart(neuronStart),
    .X1Bus(X1Bus), .X2Bus(X2Bus), .tBus(tBus), .nBus(nBus), .sampleValid(sampleValid),
    .sampleCount(sampleCount), .epochCount(epochCount), .busy(busy),
    .trainDone(trainDone), .timeout(timeout), .overflow(overflow), .emptyErr(emptyErr));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] mdl [DEPTH];
  int mcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input int x1, input int x2, input int t);
    loadX1 = DATA_W'(x1); loadX2 = DATA_W'(x2); loadT = T_W'(t);
    if (mcnt < DEPTH) begin
      mdl[mcnt] = {loadX1, loadX2, loadT};
      mcnt++;
    end
    loadValid = 1'b1; step(); loadValid = 1'b0;
  endtask

  task automatic push(input int i);
    exp_q.push_back(mdl[i]);
  endtask

  // Handshake monitor: a sample is consumed only when accept is not pre-empted.
  always @(negedge clk) begin
    if (rstN && sampleValid && neuronReady && !neuronDone && !abort) begin
      if (exp_q.size() == 0) chk("unexpected_accept", {X1Bus, X2Bus, tBus}, '1);
      else chk("sample", {X1Bus, X2Bus, tBus}, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rstN = 1'b0; loadValid = 0; clear = 0; start = 0; abort = 0;
    neuronReady = 0; neuronDone = 0; loadX1 = '0; loadX2 = '0; loadT = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", sampleValid, 0);
    chk("rst_kick", neuronStart, 0);
    chk("rst_count", sampleCount, 0);
    chk("rst_epoch", epochCount, 0);
    chk("rst_flags", {trainDone, timeout, overflow, emptyErr}, 0);
    chk("rst_nbus", nBus, 0);
    rstN = 1'b1; step();

    // Empty start
    start = 1; step(); start = 0;
    chk("empty_err", emptyErr, 1);
    chk("empty_busy", busy, 0);
    step();
    chk("empty_nokick", neuronStart, 0);

    // Run A: 5 samples
    load(3, -2, 1); load(-4, 5, -1); load(10, -7, 1); load(-1, 0, -1); load(63, -64, 1);
    chk("cnt5", sampleCount, 5);
    step();
    chk("nbus5_idle", nBus, 5);
    start = 1; step(); start = 0; neuronReady = 1;
    for (int i = 0; i < 5; i++) push(i);
    chk("kick", neuronStart, 1);
    chk("kick_busy", busy, 1);
    chk("kick_emptyclr", emptyErr, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("feed_pattern", sampleValid, (i % 2 == 0) ? 1 : 0);
      chk("epoch_step", epochCount, (i == 9) ? 1 : 0);
      if (i == 0) chk("kick_one_cycle", neuronStart, 0);
    end
    chk("epoch1_drained", exp_q.size(), 0);
    chk("nbus_run", nBus, 5);
    push(0); push(1);
    step(); step(); step(); step();
    neuronReady = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", sampleValid, 1);
      chk("stall_bus", {X1Bus, X2Bus, tBus}, mdl[2]);
      if (k < 2) step();
    end
    neuronReady = 1; push(2); push(3);
    step(); step(); step(); step();
    chk("at_last_bus", {X1Bus, X2Bus, tBus}, mdl[4]);
    neuronDone = 1;
    step(); neuronDone = 0; neuronReady = 0;
    chk("done_flag", trainDone, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", sampleValid, 0);
    chk("done_epoch_held", epochCount, 1);
    chk("done_drained", exp_q.size(), 0);

    // Run B: 3 samples, timeout after 2 epochs
    clear = 1; step(); clear = 0;
    chk("clr_cnt", sampleCount, 0);
    chk("clr_done", trainDone, 0);
    mcnt = 0;
    load(1, 2, 1); load(-3, -5, -1); load(7, 0, 1);
    start = 1; step(); start = 0; neuronReady = 1;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) push(i);
    cyc = 0;
    while (busy === 1'b1 && cyc < 60) begin step(); cyc++; end
    chk("to_bound", busy, 0);
    chk("to_flag", timeout, 1);
    chk("to_epoch", epochCount, MAXE);
    chk("to_nodone", trainDone, 0);
    chk("to_drained", exp_q.size(), 0);

    // Run C: rerun buffer, neuronDone on sample 2
    neuronReady = 0;
    start = 1; step(); start = 0;
    chk("rerun_kick", neuronStart, 1);
    chk("rerun_toclr", timeout, 0);
    chk("rerun_epoch", epochCount, 0);
    neuronReady = 1; push(0);
    step(); step(); step();
    neuronDone = 1;
    step(); neuronDone = 0; neuronReady = 0;
    chk("nd_flag", trainDone, 1);
    chk("nd_epoch", epochCount, 0);
    chk("nd_valid", sampleValid, 0);
    chk("nd_drained", exp_q.size(), 0);

    // Run D: abort beats neuronDone
    start = 1; step(); start = 0;
    step();
    abort = 1; neuronDone = 1;
    step(); abort = 0; neuronDone = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", trainDone, 0);
    chk("abort_valid", sampleValid, 0);

    // Overflow
    for (int i = 0; i < 5; i++) load(i, -i, 1);
    chk("full_cnt", sampleCount, 8);
    chk("full_noovf", overflow, 0);
    load(9, 9, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt", sampleCount, 8);

    // Reset mid-FEED
    start = 1; step(); start = 0;
    step();
    chk("pre_rst_valid", sampleValid, 1);
    rstN = 0; #1;
    chk("mid_rst_valid", sampleValid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", sampleCount, 0);
    chk("mid_rst_ovf", overflow, 0);
    step(); rstN = 1; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/perceptron_training_sequencer.md
Name: perceptron_training_sequencer

Overview:
Controller that owns the training-sample buffer and sequences the two-input neuron training datapath. It loads up to DEPTH labelled samples, pulses the neuron's start, and streams samples to the neuron epoch after epoch over a valid/ready handshake. It stops when the neuron reports convergence or an epoch limit is hit. It sits between the host/load interface and the neuron module's X1Bus/X2Bus/tBus/nBus/start inputs.

Parameters:
DATA_W, 7, signed width of X1/X2 samples
T_W, 2, signed width of target label
DEPTH, 8, sample buffer entries (power of 2)
EPOCH_W, 8, epoch counter width
MAX_EPOCHS, 100, epoch limit before timeout (1..2^EPOCH_W-1)

Ports:
clk  in  1  clock, all logic on rising edge
rstN  in  1  asynchronous active-low reset
loadValid  in  1  write one sample into buffer (IDLE/DONE only)
loadX1  in  DATA_W  sample X1
loadX2  in  DATA_W  sample X2
loadT  in  T_W  sample target
clear  in  1  empty buffer (IDLE/DONE only)
start  in  1  begin training run
abort  in  1  terminate run, return to IDLE
neuronReady  in  1  neuron readyToGetData
neuronDone  in  1  neuron done
neuronStart  out  1  one-cycle start pulse to neuron
X1Bus  out  DATA_W  sample to neuron
X2Bus  out  DATA_W  sample to neuron
tBus  out  T_W  target to neuron
nBus  out  32  sample count, zero-extended
sampleValid  out  1  X1Bus/X2Bus/tBus valid
sampleCount  out  log2(DEPTH)+1  entries loaded
epochCount  out  EPOCH_W  completed epochs
busy  out  1  run in progress
trainDone  out  1  converged, sticky until next start/clear
timeout  out  1  MAX_EPOCHS reached, sticky until next start/clear
overflow  out  1  load attempted while full, sticky until clear
emptyErr  out  1  start with zero samples, sticky until next start/clear

Behaviour:
- Reset (rstN=0, immediate): state IDLE; all outputs 0; buffer count 0, index 0, epochCount 0. Buffer contents not cleared.
- States: IDLE, KICK, FEED, GAP, DONE.
- Load: IDLE/DONE only; loadValid with count<DEPTH writes entry[count], count+1 next cycle; count==DEPTH sets overflow, no write. Loads ignored in KICK/FEED/GAP. clear beats loadValid in the same cycle.
- nBus = sampleCount registered, held stable during a run.
- IDLE/DONE + start: count==0 -> emptyErr=1, stay. Else clear trainDone/timeout/emptyErr, epochCount=0, index=0 -> KICK.
- KICK: neuronStart=1 for exactly this cycle; busy=1 -> FEED next.
- FEED: sampleValid=1, buses = entry[index]. Accept = sampleValid & neuronReady. On accept: index+1 -> GAP. If index was count-1, index wraps to 0 and epochCount+1. Buses hold until accept.
- GAP: sampleValid=0 for one cycle -> FEED. Buses keep last value. If epochCount==MAX_EPOCHS, set timeout -> DONE instead.
- neuronDone=1 in FEED/GAP: trainDone=1 -> DONE on next edge. Takes priority over accept/timeout in the same cycle; epochCount and index are not updated on that cycle.
- abort in KICK/FEED/GAP: -> IDLE next edge, sampleValid=0, flags unchanged. Abort beats neuronDone.
- DONE: busy=0, sampleValid=0; waits for start/clear/load. start re-runs with the existing buffer.
- start while busy is ignored.
- epochCount saturates at MAX_EPOCHS and never wraps.

Test Plan:
- Reset mid-FEED (rstN low 1 cycle) -> IDLE same cycle, sampleValid=0, busy=0, sampleCount=0.
- Load 5 samples {(3,-2,1),(-4,5,-1),...}, start, neuronReady=1 -> neuronStart one cycle after start; accepts every 2 cycles in order; nBus=5; epochCount increments after 5th accept.
- neuronReady low for 3 cycles mid-epoch -> sampleValid stays high, buses stable, index unchanged; resumes on ready.
- MAX_EPOCHS=2, 3 samples, neuronDone never -> timeout=1 after 6th accept, DONE, epochCount=2.
- neuronDone asserted the same cycle as accept of sample 2 -> trainDone=1, DONE, index/epochCount not advanced.
- start with empty buffer -> emptyErr=1, no neuronStart. 9th load with DEPTH=8 -> overflow=1, sampleCount=8.
